// File: rtl/dmem_pkg.sv
// Shared constants and types for the dual-issue data-memory responder.
// Optional feature macro: DMEM_MMIO_LED_EN (memory-mapped LED register at MMIO_LED_ADDR).
package dmem_pkg;

    localparam int          BANK_BIT      = 2;
    localparam int          WORD_LSB      = 2;
    localparam logic [31:0] MMIO_LED_ADDR = 32'h0000_00FC;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } access_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[WORD_LSB-1:0] != '0);
    endfunction

endpackage

// File: rtl/dmem_dual_responder_if.sv
// Request/grant/return bundle for the ODD and EVEN data-memory ports.
// The core side uses the master modport; the responder uses slave.
interface dmem_dual_responder_if;

    logic        req_odd;
    logic        we_odd;
    logic [31:0] addr_odd;
    logic [31:0] wdata_odd;
    logic        gnt_odd;
    logic        rvalid_odd;
    logic [31:0] rdata_odd;
    logic        err_odd;

    logic        req_even;
    logic        we_even;
    logic [31:0] addr_even;
    logic [31:0] wdata_even;
    logic        gnt_even;
    logic        rvalid_even;
    logic [31:0] rdata_even;
    logic        err_even;

    modport master (
        output req_odd, we_odd, addr_odd, wdata_odd,
        input  gnt_odd, rvalid_odd, rdata_odd, err_odd,
        output req_even, we_even, addr_even, wdata_even,
        input  gnt_even, rvalid_even, rdata_even, err_even
    );

    modport slave (
        input  req_odd, we_odd, addr_odd, wdata_odd,
        output gnt_odd, rvalid_odd, rdata_odd, err_odd,
        input  req_even, we_even, addr_even, wdata_even,
        output gnt_even, rvalid_even, rdata_even, err_even
    );

endinterface

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank with write enable and registered read.
// Contents are never reset; the read register only updates on a read.
module dmem_bank #(
    parameter int ROWS  = 32,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [ROW_W-1:0] row,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [ROWS];
    logic [31:0] rdata_q;

    // Write port and registered read share the single row address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[row] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[row];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_dual_responder.sv
// Dual-issue data-memory responder: two word-interleaved banks, ODD port has
// priority on a same-bank collision, EVEN is stalled and counted.
// Optional feature macro: DMEM_MMIO_LED_EN adds the ledr output and an LED
// register at byte address 0xFC (bank 1 for arbitration).
module dmem_dual_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_dual_responder_if.slave  bus,
`ifdef DMEM_MMIO_LED_EN
    output logic [15:0]           ledr,
`endif
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int ROW_W = ADDR_W - 1;
    localparam int ROWS  = DEPTH / 2;

    access_t          acc_odd, acc_even;
    logic             mis_odd, mis_even;
    logic             mmio_odd, mmio_even;
    logic             bank_odd, bank_even;
    logic [ROW_W-1:0] row_odd, row_even;
    logic             gnt_odd, gnt_even;
    logic             unused_addr_hi;

    logic             bank_we    [2];
    logic             bank_re    [2];
    logic [ROW_W-1:0] bank_row   [2];
    logic [31:0]      bank_wdata [2];
    logic [31:0]      bank_rdata [2];

    logic             rvalid_odd_d, rvalid_odd_q, rvalid_even_d, rvalid_even_q;
    logic             err_odd_d, err_odd_q, err_even_d, err_even_q;
    logic             rsel_odd_d, rsel_odd_q, rsel_even_d, rsel_even_q;
    logic             rmmio_odd_d, rmmio_odd_q, rmmio_even_d, rmmio_even_q;
    logic [31:0]      rhold_odd_d, rhold_odd_q, rhold_even_d, rhold_even_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [15:0]      led_d, led_q;
    logic [31:0]      mmio_rdata;
    logic [31:0]      ret_odd, ret_even;
    logic [31:0]      rdata_odd, rdata_even;

    assign acc_odd  = bus.we_odd  ? STORE : LOAD;
    assign acc_even = bus.we_even ? STORE : LOAD;
    assign mis_odd  = is_misaligned(bus.addr_odd);
    assign mis_even = is_misaligned(bus.addr_even);

`ifdef DMEM_MMIO_LED_EN
    assign mmio_odd   = (bus.addr_odd  == MMIO_LED_ADDR);
    assign mmio_even  = (bus.addr_even == MMIO_LED_ADDR);
    assign mmio_rdata = {16'h0000, led_q};
    assign ledr       = led_q;
`else
    assign mmio_odd   = 1'b0;
    assign mmio_even  = 1'b0;
    assign mmio_rdata = 32'h0000_0000;
`endif

    // Bits above the word index only matter for the MMIO compare; RAM wraps.
    assign unused_addr_hi = ^{bus.addr_odd[31:ADDR_W+2], bus.addr_even[31:ADDR_W+2]};

    assign bank_odd  = bus.addr_odd[BANK_BIT]  | mmio_odd;
    assign bank_even = bus.addr_even[BANK_BIT] | mmio_even;
    assign row_odd   = bus.addr_odd[ADDR_W+1:BANK_BIT+1];
    assign row_even  = bus.addr_even[ADDR_W+1:BANK_BIT+1];

    assign gnt_odd  = bus.req_odd;
    assign gnt_even = bus.req_even && !(bus.req_odd && (bank_odd == bank_even));

    assign bus.gnt_odd  = gnt_odd;
    assign bus.gnt_even = gnt_even;

    // Route each granted port to the bank it addresses; ODD wins if both map to it.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_re[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            if (gnt_odd && (bank_odd == b[0])) begin
                bank_row[b]   = row_odd;
                bank_wdata[b] = bus.wdata_odd;
                bank_we[b]    = (acc_odd == STORE) && !mis_odd && !mmio_odd;
                bank_re[b]    = (acc_odd == LOAD)  && !mis_odd && !mmio_odd;
            end else if (gnt_even && (bank_even == b[0])) begin
                bank_row[b]   = row_even;
                bank_wdata[b] = bus.wdata_even;
                bank_we[b]    = (acc_even == STORE) && !mis_even && !mmio_even;
                bank_re[b]    = (acc_even == LOAD)  && !mis_even && !mmio_even;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dmem_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .re    (bank_re[g]),
            .row   (bank_row[g]),
            .wdata (bank_wdata[g]),
            .rdata (bank_rdata[g])
        );
    end

    // Return data is the bank's read register on rvalid, otherwise the held value.
    assign ret_odd    = rmmio_odd_q  ? mmio_rdata : bank_rdata[rsel_odd_q];
    assign ret_even   = rmmio_even_q ? mmio_rdata : bank_rdata[rsel_even_q];
    assign rdata_odd  = rvalid_odd_q  ? ret_odd  : rhold_odd_q;
    assign rdata_even = rvalid_even_q ? ret_even : rhold_even_q;

    assign bus.rvalid_odd  = rvalid_odd_q;
    assign bus.rvalid_even = rvalid_even_q;
    assign bus.err_odd     = err_odd_q;
    assign bus.err_even    = err_even_q;
    assign bus.rdata_odd   = rdata_odd;
    assign bus.rdata_even  = rdata_even;
    assign conflict_cnt    = cnt_q;

    // Next-state for return path, conflict counter and LED register.
    always_comb begin
        rvalid_odd_d  = gnt_odd  && (acc_odd  == LOAD) && !mis_odd;
        rvalid_even_d = gnt_even && (acc_even == LOAD) && !mis_even;
        err_odd_d     = gnt_odd  && mis_odd;
        err_even_d    = gnt_even && mis_even;
        rsel_odd_d    = bank_odd;
        rsel_even_d   = bank_even;
        rmmio_odd_d   = mmio_odd;
        rmmio_even_d  = mmio_even;
        rhold_odd_d   = rdata_odd;
        rhold_even_d  = rdata_even;

        cnt_d = cnt_q;
        if (bus.req_even && !gnt_even && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        led_d = led_q;
        if (gnt_odd && (acc_odd == STORE) && mmio_odd) begin
            led_d = bus.wdata_odd[15:0];
        end else if (gnt_even && (acc_even == STORE) && mmio_even) begin
            led_d = bus.wdata_even[15:0];
        end
    end

    // State registers; async reset drops any in-flight return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_odd_q  <= 1'b0;
            rvalid_even_q <= 1'b0;
            err_odd_q     <= 1'b0;
            err_even_q    <= 1'b0;
            rsel_odd_q    <= 1'b0;
            rsel_even_q   <= 1'b0;
            rmmio_odd_q   <= 1'b0;
            rmmio_even_q  <= 1'b0;
            rhold_odd_q   <= '0;
            rhold_even_q  <= '0;
            cnt_q         <= '0;
            led_q         <= '0;
        end else begin
            rvalid_odd_q  <= rvalid_odd_d;
            rvalid_even_q <= rvalid_even_d;
            err_odd_q     <= err_odd_d;
            err_even_q    <= err_even_d;
            rsel_odd_q    <= rsel_odd_d;
            rsel_even_q   <= rsel_even_d;
            rmmio_odd_q   <= rmmio_odd_d;
            rmmio_even_q  <= rmmio_even_d;
            rhold_odd_q   <= rhold_odd_d;
            rhold_even_q  <= rhold_even_d;
            cnt_q         <= cnt_d;
            led_q         <= led_d;
        end
    end

endmodule

// File: tb/tb_dmem_dual_responder.sv
// Bench for dmem_dual_responder: directed steps followed by randomized traffic,
// all checked against a word-array reference model of the memory.
module tb_dmem_dual_responder;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] conflict_cnt;
`ifdef DMEM_MMIO_LED_EN
    logic [15:0]      ledr;
`endif

    dmem_dual_responder_if bus();

    dmem_dual_responder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
`ifdef DMEM_MMIO_LED_EN
        .ledr         (ledr),
`endif
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd_odd  = 32'h0;
    logic [31:0] m_rd_even = 32'h0;
    int          m_cnt = 0;
    logic [15:0] m_led = 16'h0;
    bit          last_gnt_even;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_LED_EN
        return (a == 32'h0000_00FC);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int m_word(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit m_bank(input logic [31:0] a);
        if (m_mmio(a)) return 1'b1;
        return (m_word(a) % 2) == 1;
    endfunction

    function automatic bit m_mis(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    task automatic step(input logic ro, input logic wo, input logic [31:0] ao, input logic [31:0] dto,
                        input logic re, input logic we_, input logic [31:0] ae, input logic [31:0] dte);
        bit g_o, g_e;
        @(negedge clk);
        bus.req_odd   = ro;
        bus.we_odd    = wo;
        bus.addr_odd  = ao;
        bus.wdata_odd = dto;
        bus.req_even   = re;
        bus.we_even    = we_;
        bus.addr_even  = ae;
        bus.wdata_even = dte;
        g_o = ro;
        g_e = re && !(ro && (m_bank(ao) == m_bank(ae)));
        #1;
        chk("gnt_odd",  32'(bus.gnt_odd),  32'(g_o));
        chk("gnt_even", 32'(bus.gnt_even), 32'(g_e));
        if (g_o && !wo && !m_mis(ao))
            m_rd_odd = m_mmio(ao) ? {16'h0, m_led} : m_mem[m_word(ao)];
        if (g_e && !we_ && !m_mis(ae))
            m_rd_even = m_mmio(ae) ? {16'h0, m_led} : m_mem[m_word(ae)];
        if (re && !g_e && m_cnt < CNT_MAX) m_cnt++;
        if (g_o && wo && !m_mis(ao)) begin
            if (m_mmio(ao)) m_led = dto[15:0];
            else            m_mem[m_word(ao)] = dto;
        end
        if (g_e && we_ && !m_mis(ae)) begin
            if (m_mmio(ae)) m_led = dte[15:0];
            else            m_mem[m_word(ae)] = dte;
        end
        last_gnt_even = g_e;
        @(posedge clk);
        #1;
        chk("rvalid_odd",  32'(bus.rvalid_odd),  32'(g_o && !wo && !m_mis(ao)));
        chk("err_odd",     32'(bus.err_odd),     32'(g_o && m_mis(ao)));
        chk("rdata_odd",   bus.rdata_odd,        m_rd_odd);
        chk("rvalid_even", 32'(bus.rvalid_even), 32'(g_e && !we_ && !m_mis(ae)));
        chk("err_even",    32'(bus.err_even),    32'(g_e && m_mis(ae)));
        chk("rdata_even",  bus.rdata_even,       m_rd_even);
        chk("conflict_cnt", 32'(conflict_cnt),   32'(m_cnt));
`ifdef DMEM_MMIO_LED_EN
        chk("ledr", 32'(ledr), 32'(m_led));
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FF00);
        return a;
    endfunction

    initial begin
        logic        ro, wo, re, we_, pend;
        logic [31:0] ao, dto, ae, dte;

        bus.req_odd = 1'b0;  bus.we_odd = 1'b0;  bus.addr_odd = '0;  bus.wdata_odd = '0;
        bus.req_even = 1'b0; bus.we_even = 1'b0; bus.addr_even = '0; bus.wdata_even = '0;

        // reset state
        #2;
        chk("rst_rvalid_odd",  32'(bus.rvalid_odd),  32'h0);
        chk("rst_rvalid_even", 32'(bus.rvalid_even), 32'h0);
        chk("rst_err_odd",     32'(bus.err_odd),     32'h0);
        chk("rst_rdata_odd",   bus.rdata_odd,        32'h0);
        chk("rst_rdata_even",  bus.rdata_even,       32'h0);
        chk("rst_cnt",         32'(conflict_cnt),    32'h0);
        @(negedge clk);
        reset = 1'b1;

        // fill every word, ODD on bank 0 and EVEN on bank 1
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b1, 32'(i * 8), $urandom, 1'b1, 1'b1, 32'(i * 8 + 4), $urandom);

        // store then load from the other port
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("store_load_data", bus.rdata_even, 32'hDEAD_BEEF);

        // same-address store/store: EVEN stalled once, EVEN value persists
        step(1'b1, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
        chk("conflict_first", 32'(conflict_cnt), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("store_order", bus.rdata_odd, 32'h2222_2222);

        // ODD store, EVEN load same address: EVEN sees the new value after its stall
        step(1'b1, 1'b1, 32'h30, 32'h3333_3333, 1'b1, 1'b0, 32'h30, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);

        // different-bank loads in one cycle
        step(1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);

        // misaligned EVEN load, then confirm word 0x04 untouched
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h06, 32'h0);
        step(1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b1, 32'h0B, 32'h5555_5555);
        idle();

        // wrap: 0x100 aliases 0x00
        step(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00, 32'h0);
        chk("wrap_data", bus.rdata_even, 32'hCAFE_F00D);

        // counter saturation with a held EVEN request
        for (int i = 0; i < CNT_MAX + 4; i++)
            step(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);
        chk("cnt_saturated", 32'(conflict_cnt), 32'(CNT_MAX));
        idle();

`ifdef DMEM_MMIO_LED_EN
        step(1'b1, 1'b1, 32'hFC, 32'h0000_A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("ledr_a5a5", 32'(ledr), 32'h0000_A5A5);
        step(1'b1, 1'b0, 32'hF8, 32'h0, 1'b1, 1'b0, 32'hFC, 32'h0);
        step(1'b1, 1'b0, 32'hF4, 32'h0, 1'b1, 1'b0, 32'hFC, 32'h0);
`endif

        // reset in the cycle after a load grant, with the load request still held
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        m_rd_odd = 32'h0; m_rd_even = 32'h0; m_cnt = 0; m_led = 16'h0;
        chk("arst_rvalid_odd", 32'(bus.rvalid_odd), 32'h0);
        chk("arst_rdata_odd",  bus.rdata_odd,       32'h0);
        chk("arst_cnt",        32'(conflict_cnt),   32'h0);
        @(posedge clk);
        #1;
        chk("arst_drop_load",  32'(bus.rvalid_odd), 32'h0);
        bus.req_odd = 1'b0;
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        chk("post_reset_data", bus.rdata_odd, 32'hDEAD_BEEF);

        // randomized traffic; a stalled EVEN request is held until granted
        pend = 1'b0;
        re = 1'b0; we_ = 1'b0; ae = '0; dte = '0;
        for (int i = 0; i < 600; i++) begin
            ro  = 1'($urandom_range(0, 1));
            wo  = 1'($urandom_range(0, 1));
            ao  = rand_addr();
            dto = $urandom;
            if (!pend) begin
                re  = ($urandom_range(0, 2) != 0);
                we_ = 1'($urandom_range(0, 1));
                ae  = rand_addr();
                dte = $urandom;
            end
            step(ro, wo, ao, dto, re, we_, ae, dte);
            pend = re && !last_gnt_even;
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
